imem_loader: RTL



---
 rtl/imem_loader.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Program loader: accepts 32-bit instruction words over a valid/ready stream
// and writes them big-endian, one byte per cycle, into byte-addressed instruction memory.
module imem_loader #(
  parameter int unsigned MEM_BYTES = 256,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      start_addr,
  input  logic [31:0]      word_in,
  input  logic             word_valid,
  input  logic             word_last,
  output logic             word_ready,
  output logic             mem_write_en,
  output logic [31:0]      mem_write_addr,
  output logic [7:0]       mem_write_data,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] words_written
);

  localparam int unsigned AW = $clog2(MEM_BYTES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEPT = 2'd1,
    WRITE  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t          state, state_d;
  logic [AW-1:0]   ptr, ptr_d;
  logic [1:0]      idx, idx_d;
  logic [31:0]     wrd, wrd_d;
  logic            last, last_d;
  logic [CNT_W-1:0] cnt_d;
  logic            err_d;

  logic            word_ready_d;
  logic            mem_write_en_d;
  logic [AW-1:0]   addr_d;
  logic [7:0]      data_d;
  logic            busy_d;
  logic            done_d;

  // Next-state logic; outputs are computed from the next state so they can be registered
  always_comb begin
    state_d        = state;
    ptr_d          = ptr;
    idx_d          = idx;
    wrd_d          = wrd;
    last_d         = last;
    cnt_d          = words_written;
    err_d          = error;
    word_ready_d   = 1'b0;
    mem_write_en_d = 1'b0;
    addr_d         = '0;
    data_d         = '0;
    busy_d         = 1'b0;
    done_d         = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          if (start_addr[1:0] == 2'd0) begin
            ptr_d   = AW'(start_addr % 32'(MEM_BYTES));
            cnt_d   = '0;
            err_d   = 1'b0;
            state_d = ACCEPT;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ACCEPT: begin
        if (word_valid) begin
          wrd_d   = word_in;
          last_d  = word_last;
          idx_d   = 2'd0;
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (idx == 2'd3) begin
          ptr_d   = ptr + AW'(4);
          cnt_d   = words_written + CNT_W'(1);
          state_d = last ? DONE : ACCEPT;
        end else begin
          idx_d = idx + 2'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    word_ready_d   = (state_d == ACCEPT);
    mem_write_en_d = (state_d == WRITE);
    busy_d         = (state_d != IDLE);
    done_d         = (state_d == DONE);
    if (mem_write_en_d) begin
      addr_d = ptr_d + AW'(idx_d);
      unique case (idx_d)
        2'd0: data_d = wrd_d[31:24];
        2'd1: data_d = wrd_d[23:16];
        2'd2: data_d = wrd_d[15:8];
        2'd3: data_d = wrd_d[7:0];
        default: data_d = '0;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      ptr            <= '0;
      idx            <= '0;
      wrd            <= '0;
      last           <= 1'b0;
      words_written  <= '0;
      error          <= 1'b0;
      word_ready     <= 1'b0;
      mem_write_en   <= 1'b0;
      mem_write_addr <= '0;
      mem_write_data <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      state          <= state_d;
      ptr            <= ptr_d;
      idx            <= idx_d;
      wrd            <= wrd_d;
      last           <= last_d;
      words_written  <= cnt_d;
      error          <= err_d;
      word_ready     <= word_ready_d;
      mem_write_en   <= mem_write_en_d;
      mem_write_addr <= 32'(addr_d);
      mem_write_data <= data_d;
      busy           <= busy_d;
      done           <= done_d;
    end
  end

endmodule
